// File: rtl/collide_arbiter_pkg.sv
// Shared types and constants for the sphere-collision blocks.
// Arbiter FSM states, float word type and index-width helper.
package collide_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef logic [31:0] fp32_t;

    localparam fp32_t FP_ONE = 32'h3F80_0000;
    localparam fp32_t FP_TWO = 32'h4000_0000;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/collide_arbiter_rr_picker.sv
// Combinational round-robin priority encoder.
// Picks the first set request at or after ptr, wrapping cyclically.
module rr_picker
    import collide_arbiter_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/collide_arbiter.sv
// Round-robin arbiter sharing one sphere-collision engine among
// N_REQ requesters, one job in flight, with a WAIT timeout.
module collide_arbiter
    import collide_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1023,
    localparam int IW = idx_w(N_REQ),
    localparam int CW = $clog2(TIMEOUT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*32-1:0] req_g1,
    input  logic [N_REQ*32-1:0] req_g2,
    output logic                eng_start,
    output logic [31:0]         eng_g1,
    output logic [31:0]         eng_g2,
    input  logic                eng_done,
    input  logic                eng_ret,
    input  logic [31:0]         eng_depth,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IW-1:0]       rsp_id,
    output logic                rsp_ret,
    output logic [31:0]         rsp_depth,
    output logic                rsp_err
);

    state_t         state;
    state_t         state_nx;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  job_id;
    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]  gnt_idx;
    logic           gnt_any;
    logic [CW-1:0]  tmo_cnt;
    logic           tmo_hit;
    logic [15:0]    jobs_done;
    logic           grant_en;
    logic           launch;
    logic           rsp_fire;

    rr_picker #(.N(N_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (gnt_any) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (eng_done || tmo_hit) state_nx = S_RESP;
            S_RESP:  if (rsp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = (state == S_RESP);
        grant_en  = (state == S_IDLE) && gnt_any;
        launch    = (state == S_ISSUE);
        rsp_fire  = rsp_valid && rsp_ready;
    end

    // Strobes are registered, giving the two-cycle grant-to-launch latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            job_id    <= '0;
            req_ready <= '0;
            eng_start <= 1'b0;
            eng_g1    <= '0;
            eng_g2    <= '0;
            tmo_cnt   <= '0;
            rsp_id    <= '0;
            rsp_ret   <= 1'b0;
            rsp_depth <= '0;
            rsp_err   <= 1'b0;
            jobs_done <= '0;
        end else begin
            req_ready <= '0;
            eng_start <= 1'b0;
            if (grant_en) begin
                req_ready <= gnt;
                eng_g1    <= req_g1[32*gnt_idx +: 32];
                eng_g2    <= req_g2[32*gnt_idx +: 32];
                job_id    <= gnt_idx;
                rr_ptr    <= (gnt_idx == IW'(N_REQ - 1)) ? '0
                                                         : gnt_idx + 1'b1;
            end
            if (launch) begin
                eng_start <= 1'b1;
                tmo_cnt   <= '0;
            end
            if (state == S_WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (eng_done) begin
                    rsp_id    <= job_id;
                    rsp_ret   <= eng_ret;
                    rsp_depth <= eng_depth;
                    rsp_err   <= 1'b0;
                end else if (tmo_hit) begin
                    rsp_id    <= job_id;
                    rsp_ret   <= 1'b0;
                    rsp_depth <= '0;
                    rsp_err   <= 1'b1;
                end
            end
            if (rsp_fire) jobs_done <= jobs_done + 16'd1;
        end
    end

endmodule

// File: tb/tb_collide_arbiter.sv
// Directed-vector bench for collide_arbiter.
// Table of jobs plus hand sequences for hold, fairness and reset.
module tb_collide_arbiter;
    import collide_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int T   = 20;
    localparam int BUD = 2 * T + 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*32-1:0] req_g1;
    logic [N*32-1:0] req_g2;
    logic          eng_start;
    logic [31:0]   eng_g1, eng_g2;
    logic          eng_done = 1'b0;
    logic          eng_ret = 1'b0;
    logic [31:0]   eng_depth = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_id;
    logic          rsp_ret;
    logic [31:0]   rsp_depth;
    logic          rsp_err;

    int total = 0;
    int bad = 0;
    int jd = 0;

    logic [31:0] g1tab [N];
    logic [31:0] g2tab [N];

    collide_arbiter #(.N_REQ(N), .TIMEOUT(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_g1    (req_g1),
        .req_g2    (req_g2),
        .eng_start (eng_start),
        .eng_g1    (eng_g1),
        .eng_g2    (eng_g2),
        .eng_done  (eng_done),
        .eng_ret   (eng_ret),
        .eng_depth (eng_depth),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_ret   (rsp_ret),
        .rsp_depth (rsp_depth),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        int          id;
        int          d;
        logic        ret;
        logic [31:0] depth;
        logic        x_ret;
        logic [31:0] x_depth;
        logic        x_err;
    } vec_t;

    vec_t tab [7];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_job(input vec_t t, input bit keep, input int hold);
        int n;
        int unst;
        logic [4:0] snap;
        logic [31:0] sdep;
        n = 0;
        unst = 0;
        eng_ret = t.ret;
        eng_depth = t.depth;
        req_valid = t.v;
        @(posedge clk); #1;
        chk("req_ready", 64'(req_ready), 64'(4'b1 << t.id));
        chk("start_early", 64'(eng_start), 64'd0);
        if (!keep) req_valid = '0;
        @(posedge clk); #1;
        chk("eng_start", 64'(eng_start), 64'd1);
        chk("eng_g1", 64'(eng_g1), 64'(g1tab[t.id]));
        chk("eng_g2", 64'(eng_g2), 64'(g2tab[t.id]));
        chk("ready_pulse", 64'(req_ready), 64'd0);
        if (t.d >= 0) begin
            repeat (t.d) begin
                @(posedge clk); #1;
                n++;
            end
            eng_done = 1'b1;
        end
        while (!rsp_valid && n < BUD) begin
            @(posedge clk); #1;
            n++;
            eng_done = 1'b0;
        end
        eng_done = 1'b0;
        chk("rsp_latency", 64'(n), 64'((t.d >= 0) ? t.d + 1 : T));
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("start_once", 64'(eng_start), 64'd0);
        chk("rsp_id", 64'(rsp_id), 64'(t.id));
        chk("rsp_ret", 64'(rsp_ret), 64'(t.x_ret));
        chk("rsp_depth", 64'(rsp_depth), 64'(t.x_depth));
        chk("rsp_err", 64'(rsp_err), 64'(t.x_err));
        snap = {rsp_valid, rsp_id, rsp_ret, rsp_err};
        sdep = rsp_depth;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if ({rsp_valid, rsp_id, rsp_ret, rsp_err} !== snap ||
                rsp_depth !== sdep || eng_start !== 1'b0 ||
                req_ready !== '0)
                unst++;
        end
        if (hold > 0) chk("rsp_hold", 64'(unst), 64'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        jd++;
        chk("rsp_drop", 64'(rsp_valid), 64'd0);
        chk("jobs_done", 64'(dut.jobs_done), 64'(jd));
    endtask

    initial begin
        vec_t h;
        g1tab[0] = 32'h1111_0000;
        g1tab[1] = 32'h2222_0000;
        g1tab[2] = FP_ONE;
        g1tab[3] = 32'h4444_0000;
        for (int i = 0; i < N; i++) begin
            g2tab[i] = g1tab[i] ^ 32'h0000_FFFF;
            req_g1[32*i +: 32] = g1tab[i];
            req_g2[32*i +: 32] = g2tab[i];
        end

        tab[0] = '{4'b0100, 2, 3, 1'b1, FP_TWO, 1'b1, FP_TWO, 1'b0};
        tab[1] = '{4'b1111, 3, 0, 1'b0, 32'h1234_5678, 1'b0,
                   32'h1234_5678, 1'b0};
        tab[2] = '{4'b0110, 1, 5, 1'b1, 32'h0000_0001, 1'b1,
                   32'h0000_0001, 1'b0};
        tab[3] = '{4'b0011, 0, 2, 1'b1, 32'h0BAD_F00D, 1'b1,
                   32'h0BAD_F00D, 1'b0};
        tab[4] = '{4'b1000, 3, -1, 1'b1, 32'hFFFF_FFFF, 1'b0,
                   32'h0, 1'b1};
        tab[5] = '{4'b0001, 0, T - 1, 1'b1, 32'hDEAD_BEEF, 1'b1,
                   32'hDEAD_BEEF, 1'b0};
        tab[6] = '{4'b1001, 3, 1, 1'b0, 32'h0000_0042, 1'b0,
                   32'h0000_0042, 1'b0};

        #12;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_start", 64'(eng_start), 64'd0);
        chk("rst_g1", 64'(eng_g1), 64'd0);
        chk("rst_rsp", 64'({rsp_valid, rsp_id, rsp_ret, rsp_err}), 64'd0);
        chk("rst_depth", 64'(rsp_depth), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        eng_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        eng_done = 1'b0;
        chk("idle_done_ignored", 64'({rsp_valid, eng_start}), 64'd0);

        for (int i = 0; i < 7; i++) run_job(tab[i], 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            h = '{4'b1111, i % 4, 1, 1'b1, 32'(i), 1'b1, 32'(i), 1'b0};
            run_job(h, 1'b1, 0);
        end
        req_valid = '0;

        h = '{4'b0010, 1, 2, 1'b1, 32'h0055_AA00, 1'b1,
              32'h0055_AA00, 1'b0};
        run_job(h, 1'b1, 10);
        req_valid = '0;

        req_valid = 4'b0100;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        jd = 0;
        chk("mid_rst_start", 64'(eng_start), 64'd0);
        chk("mid_rst_g", 64'({eng_g1, eng_g2}), 64'd0);
        chk("mid_rst_rsp", 64'({rsp_valid, rsp_id, rsp_ret, rsp_err}),
            64'd0);
        chk("mid_rst_jobs", 64'(dut.jobs_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (T + 3) @(posedge clk);
        #1;
        chk("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
        h = '{4'b1111, 0, 0, 1'b1, FP_ONE, 1'b1, FP_ONE, 1'b0};
        run_job(h, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/collide_arbiter.md
COLLIDE_ARBITER -- requirements
Module: collide_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one sphere-collision engine.
REQ-002 Parameter TIMEOUT, default 1023, max cycles in WAIT before abort.
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  in  N_REQ  per-requester request pending.
REQ-006 req_ready  out  N_REQ  one-hot accept strobe to the granted requester.
REQ-007 req_g1, req_g2  in  N_REQ*32 each  packed geometry words per requester.
REQ-008 eng_start  out  1  one-cycle launch pulse to the engine.
REQ-009 eng_g1, eng_g2  out  32 each  operands held stable from eng_start until engine done or abort.
REQ-010 eng_done  in  1  engine completion, sampled only in WAIT.
REQ-011 eng_ret  in  1  engine collide flag; eng_depth  in  32  engine depth word.
REQ-012 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-013 rsp_id  out  clog2(N_REQ)  requester index; rsp_ret  out  1; rsp_depth  out  32; rsp_err  out  1  timeout flag.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT, RESP; exactly one engine job in flight.
REQ-015 IDLE: if any req_valid, grant the first set bit at or after rr_ptr (cyclic), latch its g1/g2 and index, pulse req_ready for that bit only, go ISSUE.
REQ-016 ISSUE: assert eng_start for exactly one cycle, clear timeout counter, go WAIT.
REQ-017 WAIT: on eng_done latch eng_ret/eng_depth, rsp_err=0, go RESP; counter increments each WAIT cycle.
REQ-018 WAIT: when counter reaches TIMEOUT without eng_done, go RESP with rsp_ret=0, rsp_depth=0, rsp_err=1.
REQ-019 eng_done and timeout in the same cycle: eng_done wins, rsp_err=0.
REQ-020 RESP: rsp_valid high, rsp_* held stable until rsp_valid&&rsp_ready, then IDLE; request issue latency IDLE->eng_start = 2 cycles.
REQ-021 rr_ptr updates to (granted index+1) mod N_REQ at each grant; wraps from N_REQ-1 to 0.
REQ-022 req_valid changes outside IDLE are ignored; requests are never lost, only deferred.
REQ-023 eng_done outside WAIT is ignored.
REQ-024 Status counter jobs_done 16-bit, increments on each RESP handshake, wraps at 65535->0 (internal, observable by bench).

Reset
REQ-025 On rst_n low: state IDLE, rr_ptr 0, counters 0, req_ready 0, eng_start 0, eng_g1/eng_g2 0, rsp_valid 0, rsp_id 0, rsp_ret 0, rsp_depth 0, rsp_err 0.
REQ-026 Reset mid-job abandons the job with no response; engine reset is the integrator's responsibility.

Structure
REQ-027 Shared package holds state enum, 32-bit float word typedef and FP_ONE/FP_TWO constants used across collision blocks.
REQ-028 One sub-module rr_picker (combinational round-robin priority encoder: req vector, pointer -> one-hot grant, index, any).

Verification
REQ-029 Single req_valid[2]=1, g1=0x3F800000 -> req_ready=0100, eng_start 2 cycles later with eng_g1=0x3F800000; eng_done ret=1 depth=0x40000000 -> rsp_id=2, rsp_ret=1, rsp_err=0.
REQ-030 All four req_valid held high for 8 jobs -> grant order 0,1,2,3,0,1,2,3.
REQ-031 eng_done never asserted -> RESP after TIMEOUT WAIT cycles with rsp_err=1, rsp_ret=0, rsp_depth=0.
REQ-032 eng_done on the TIMEOUT cycle -> rsp_err=0, engine values returned.
REQ-033 rsp_ready low 10 cycles -> rsp_* stable, no new eng_start until handshake.
REQ-034 rst_n pulsed low during WAIT -> all outputs at reset values immediately, no response, next grant from index 0.
